dot_matrix_text_sequencer: RTL and testbench
============================================

// Module: dot_matrix_text_sequencer
// PURPOSE
//   Sequences a short text message onto the 8x8 ASCII dot-matrix driver: stores up to DEPTH
//   7-bit characters and presents them one at a time on ascii_code, with a fixed dwell per
//   character and an optional blank gap between characters. A priority override channel
//   (score/status display) preempts playback; playback then resumes where it stopped.
//   Sits between game logic and the dot-matrix row/column driver.
// PARAMETERS
//   DEPTH  16          message buffer size in characters (power of 2, >= 2)
//   DWELL  50_000_000  clk cycles each character is shown (>= 1)
//   GAP    5_000_000   clk cycles of blank (0x20) between characters; 0 = no gap
//   TW     26          timer width; must hold max(DWELL, GAP) - 1
// PORTS
//   clk         in   1             system clock, rising edge
//   rst_n       in   1             asynchronous active-low reset
//   wr_en       in   1             append wr_char to buffer (accepted only in IDLE, not full)
//   wr_char     in   7             ASCII character to append
//   clear       in   1             empty the buffer (accepted only in IDLE)
//   start       in   1             begin playback of buffer from index 0
//   loop        in   1             sampled at end of last char: 1 = restart at index 0
//   stop        in   1             abort playback, return to IDLE, no done pulse
//   ovr_req     in   1             override request (level)
//   ovr_char    in   7             character shown while override granted
//   ovr_gnt     out  1             override granted (registered)
//   ascii_code  out  7             character to the dot-matrix driver (registered)
//   busy        out  1             1 in any state other than IDLE
//   done        out  1             one-cycle pulse when non-looping playback completes
//   count       out  $clog2(DEPTH)+1  number of stored characters
//   full        out  1             count == DEPTH
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE, count=0, idx=0, timer=0, ascii_code=7'h20,
//     ovr_gnt=0, done=0, busy=0; buffer contents are don't-care.
//   States: IDLE, SHOW, GAP. Override is an orthogonal freeze flag, not a state.
//   IDLE: ascii_code=0x20. wr_en & !full -> buf[count]<=wr_char, count+1. wr_en when full
//     or busy is dropped silently. clear -> count=0; clear wins over wr_en same cycle.
//     start with count!=0 (value before this cycle's write/clear) -> SHOW, idx=0,
//     timer=DWELL-1. start with count==0 -> ignored; a same-cycle write is still accepted.
//   SHOW: ascii_code=buf[idx]. Timer decrements each cycle; at timer==0:
//     if idx != count-1: GAP>0 -> GAP with timer=GAP-1, else SHOW idx+1, timer=DWELL-1.
//     if idx == count-1: loop=1 -> same as above with idx wrapping to 0;
//       loop=0 -> IDLE, done=1 for exactly one cycle, ascii_code=0x20.
//   GAP: ascii_code=0x20; at timer==0 -> SHOW idx+1 (or 0 on wrap), timer=DWELL-1.
//   Latency: state/idx change at edge N appears on ascii_code at edge N (output registered
//     from next-state values); one char shown for exactly DWELL cycles, gap exactly GAP.
//   Override: ovr_req=1 sampled at edge N -> ovr_gnt=1 and ascii_code=ovr_char from edge N;
//     ovr_char tracked every cycle while granted. While granted, timer, idx and state are
//     frozen (also in IDLE). ovr_req=0 -> ovr_gnt=0 next edge, display resumes with the
//     remaining timer value (no restart of dwell).
//   stop (any state, highest priority after reset): -> IDLE next edge, done stays 0,
//     buffer and count kept. stop overrides simultaneous timer expiry and start.
//   start while busy: ignored. wr_en/clear while busy: ignored.
//   done never asserts while ovr_gnt=1 (expiry cannot occur while frozen).
// TESTING (sim with DWELL=4, GAP=2, DEPTH=4)
//   Write 'H','I' then start -> ascii_code 'H' x4, 0x20 x2, 'I' x4, then 0x20 + done=1 one cycle.
//   Write 5 chars with DEPTH=4 -> count=4, full=1, 5th dropped; clear+wr_en same cycle -> count=0.
//   loop=1 with 'A','B' -> A x4, gap x2, B x4, gap x2, A x4 ...; no done pulse.
//   ovr_req high 3 cycles at 2nd cycle of 'A' -> ovr_char x3, then 'A' for remaining 2 cycles.
//   stop during GAP -> IDLE next edge, ascii_code=0x20, done=0, count unchanged.
//   rst_n low mid-SHOW -> immediate ascii_code=0x20, busy=0, count=0, ovr_gnt=0.

Source files
------------

// File: rtl/dot_matrix_text_sequencer.sv
// Plays a stored text message one character at a time onto the dot-matrix driver,
// with a fixed dwell per character, an optional blank gap, and a freezing priority override.
module dot_matrix_text_sequencer #(
  parameter int DEPTH = 16,
  parameter int DWELL = 50_000_000,
  parameter int GAP   = 5_000_000,
  parameter int TW    = 26
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [6:0]                 wr_char,
  input  logic                       clear,
  input  logic                       start,
  input  logic                       loop,
  input  logic                       stop,
  input  logic                       ovr_req,
  input  logic [6:0]                 ovr_char,
  output logic                       ovr_gnt,
  output logic [6:0]                 ascii_code,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam logic [TW-1:0] DWELL_LD = TW'(DWELL - 1);
  localparam logic [TW-1:0] GAP_LD   = (GAP > 0) ? TW'(GAP - 1) : '0;
  localparam logic [6:0]    BLANK    = 7'h20;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GAPS
  } state_t;

  state_t          state, state_n;
  logic [IW-1:0]   idx, idx_n;
  logic [TW-1:0]   timer, timer_n;
  logic [CW-1:0]   count_n;
  logic            done_n;
  logic [6:0]      ascii_n;
  logic [6:0]      mem [DEPTH];
  logic            wr_ok;
  logic            last;
  logic [IW-1:0]   idx_adv;

  assign full    = (count == CW'(DEPTH));
  assign busy    = (state != IDLE);
  assign last    = ({1'b0, idx} == count - CW'(1));
  assign idx_adv = last ? '0 : idx + 1'b1;
  assign wr_ok   = (state == IDLE) && wr_en && !clear && !full;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    timer_n = timer;
    done_n  = 1'b0;
    count_n = count;

    if (state == IDLE) begin
      if (clear)
        count_n = '0;
      else if (wr_ok)
        count_n = count + CW'(1);
    end

    if (stop) begin
      state_n = IDLE;
    end else if (!ovr_req) begin
      unique case (state)
        IDLE: begin
          if (start && count != '0) begin
            state_n = SHOW;
            idx_n   = '0;
            timer_n = DWELL_LD;
          end
        end
        SHOW: begin
          if (timer != '0) begin
            timer_n = timer - 1'b1;
          end else if (last && !loop) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else if (GAP > 0) begin
            state_n = GAPS;
            timer_n = GAP_LD;
          end else begin
            idx_n   = idx_adv;
            timer_n = DWELL_LD;
          end
        end
        GAPS: begin
          if (timer != '0) begin
            timer_n = timer - 1'b1;
          end else begin
            state_n = SHOW;
            idx_n   = idx_adv;
            timer_n = DWELL_LD;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    // output is registered from next-state values so it changes on the same edge
    if (ovr_req)
      ascii_n = ovr_char;
    else if (state_n == SHOW)
      ascii_n = mem[idx_n];
    else
      ascii_n = BLANK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      timer      <= '0;
      count      <= '0;
      done       <= 1'b0;
      ovr_gnt    <= 1'b0;
      ascii_code <= BLANK;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      timer      <= timer_n;
      count      <= count_n;
      done       <= done_n;
      ovr_gnt    <= ovr_req;
      ascii_code <= ascii_n;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[count[IW-1:0]] <= wr_char;
  end

endmodule

// File: tb/tb_dot_matrix_text_sequencer.sv
// Directed bench for the text sequencer, small timing parameters.
// Outputs are sampled 1 time unit after each rising edge.
module tb_dot_matrix_text_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, clear, start, loop, stop, ovr_req;
  logic [6:0] wr_char, ovr_char;
  logic       ovr_gnt, busy, done, full;
  logic [6:0] ascii_code;
  logic [2:0] count;

  int total = 0;
  int bad   = 0;

  dot_matrix_text_sequencer #(
    .DEPTH(4), .DWELL(4), .GAP(2), .TW(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_char(wr_char),
    .clear(clear), .start(start),
    .loop(loop), .stop(stop),
    .ovr_req(ovr_req), .ovr_char(ovr_char),
    .ovr_gnt(ovr_gnt), .ascii_code(ascii_code),
    .busy(busy), .done(done),
    .count(count), .full(full)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [6:0] seq_hi [11];
  logic [6:0] seq_ab [16];

  initial begin
    seq_hi = '{7'h48, 7'h48, 7'h48, 7'h48, 7'h20, 7'h20,
               7'h49, 7'h49, 7'h49, 7'h49, 7'h20};
    seq_ab = '{7'h41, 7'h41, 7'h41, 7'h41, 7'h20, 7'h20,
               7'h42, 7'h42, 7'h42, 7'h42, 7'h20, 7'h20,
               7'h41, 7'h41, 7'h41, 7'h41};

    rst_n = 1'b0; wr_en = 0; clear = 0; start = 0;
    loop = 0; stop = 0; ovr_req = 0;
    wr_char = 7'h0; ovr_char = 7'h0;
    #12;
    chk("rst_ascii", 32'(ascii_code), 32'h20);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_gnt",   32'(ovr_gnt), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_full",  32'(full), 0);
    rst_n = 1'b1;
    step();

    // 'H','I' with gap and done pulse
    wr_en = 1; wr_char = 7'h48; step();
    wr_char = 7'h49; step();
    wr_en = 0;
    chk("hi_count", 32'(count), 2);
    start = 1; step(); start = 0;
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("hi_ascii[%0d]", i), 32'(ascii_code), 32'(seq_hi[i]));
      chk($sformatf("hi_done[%0d]", i), 32'(done), (i == 10) ? 1 : 0);
      if (i < 10) step();
    end
    chk("hi_idle", 32'(busy), 0);
    step();
    chk("hi_done_end", 32'(done), 0);

    // fill, overflow, clear vs write
    clear = 1; step(); clear = 0;
    chk("clr_count", 32'(count), 0);
    wr_en = 1;
    for (int i = 0; i < 5; i++) begin
      wr_char = 7'(7'h41 + i); step();
    end
    wr_en = 0;
    chk("fill_count", 32'(count), 4);
    chk("fill_full", 32'(full), 1);
    clear = 1; wr_en = 1; step(); clear = 0; wr_en = 0;
    chk("clrwr_count", 32'(count), 0);
    chk("clrwr_full", 32'(full), 0);
    start = 1; wr_en = 1; wr_char = 7'h41; step(); start = 0;
    chk("start_empty_busy", 32'(busy), 0);
    chk("start_empty_wr", 32'(count), 1);
    wr_char = 7'h42; step(); wr_en = 0;
    chk("ab_count", 32'(count), 2);

    // looping playback
    loop = 1; start = 1; step(); start = 0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("loop_ascii[%0d]", i), 32'(ascii_code), 32'(seq_ab[i]));
      chk($sformatf("loop_done[%0d]", i), 32'(done), 0);
      step();
    end
    chk("loop_gap", 32'(ascii_code), 32'h20);
    chk("loop_busy", 32'(busy), 1);
    stop = 1; step(); stop = 0; loop = 0;
    chk("stop_ascii", 32'(ascii_code), 32'h20);
    chk("stop_busy", 32'(busy), 0);
    chk("stop_done", 32'(done), 0);
    chk("stop_count", 32'(count), 2);

    // override freeze and resume
    start = 1; step(); start = 0;
    chk("ovr_a0", 32'(ascii_code), 32'h41);
    step();
    ovr_req = 1; ovr_char = 7'h5a; step();
    chk("ovr_z", 32'(ascii_code), 32'h5a);
    chk("ovr_gnt1", 32'(ovr_gnt), 1);
    ovr_char = 7'h59; step();
    chk("ovr_track", 32'(ascii_code), 32'h59);
    step();
    chk("ovr_y3", 32'(ascii_code), 32'h59);
    ovr_req = 0; step();
    chk("res_a1", 32'(ascii_code), 32'h41);
    chk("res_gnt0", 32'(ovr_gnt), 0);
    step();
    chk("res_a2", 32'(ascii_code), 32'h41);
    step();
    chk("res_gap", 32'(ascii_code), 32'h20);
    step(); step();
    chk("res_b", 32'(ascii_code), 32'h42);

    // async reset mid-SHOW while granted
    ovr_req = 1; step();
    chk("pre_rst_gnt", 32'(ovr_gnt), 1);
    #2 rst_n = 1'b0; #1;
    chk("arst_ascii", 32'(ascii_code), 32'h20);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_gnt", 32'(ovr_gnt), 0);
    ovr_req = 0;
    rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
